bvh_node_unpacker: RTL and testbench
====================================

// Module: bvh_node_unpacker
// PURPOSE
//  Decodes 128-bit packed BVH node words into traversal-ready fields. Sits between the
//  node-fetch memory return and the ray traversal scheduler. Converts relative child
//  offsets to absolute node addresses. Optionally expands a leaf into one beat per primitive.
// PARAMETERS
//  ADDR_W       32  width of node addresses, in node (128-bit) units
//  LEAF_EXPAND  1   1: leaf emits one beat per primitive; 0: leaf emits a single beat
// PORTS
//  clk              in   1       clock
//  rst              in   1       asynchronous reset, active-high
//  in_valid         in   1       node word valid
//  in_ready         out  1       unpacker accepts node this cycle
//  in_node_word     in   128     {max_z,max_y,max_x,min_z,min_y,min_x,union[31:0]}, 16b each
//  in_is_leaf       in   1       sideband node type (not encoded in the word)
//  in_node_addr     in   ADDR_W  address of this node
//  out_valid        out  1       decoded beat valid
//  out_ready        in   1       consumer accepts beat
//  out_is_leaf      out  1       beat comes from a leaf
//  out_axis         out  2       split axis (interior), 0 for leaf
//  out_child0_addr  out  ADDR_W  absolute child0 address (interior), 0 for leaf
//  out_child1_addr  out  ADDR_W  absolute child1 address (interior), 0 for leaf
//  out_bbox_min     out  48      {min_z,min_y,min_x}
//  out_bbox_max     out  48      {max_z,max_y,max_x}
//  out_prim_index   out  20      primitive index (leaf; base when LEAF_EXPAND=0)
//  out_prim_count   out  12      leaf primitive count as decoded
//  out_first        out  1       first beat of a node
//  out_last         out  1       last beat of a node
//  out_empty        out  1       leaf with prim_count==0
// BEHAVIOUR
//  Union decode: interior [31:30]=axis,[29:15]=child0_off,[14:0]=child1_off;
//   leaf [31:12]=prim_index,[11:0]=prim_count.
//  childN_addr = in_node_addr + zero-extended offset, modulo 2^ADDR_W.
//  Reset: all out_* registers 0, state IDLE; in_ready forced 0 while rst high.
//  Output is a single register stage: 1-cycle latency from input handshake to out_valid.
//  Held beat (out_valid & !out_ready): every out_* stable until accepted.
//  in_ready = !rst & (state==IDLE) & (!out_valid | out_ready) -- combinational.
//  States: IDLE, EXPAND.
//   IDLE, input fire, interior: load beat, first=last=1; stay IDLE. Full throughput
//    (one interior node per cycle) with out_ready held high.
//   IDLE, fire, leaf count 0: one beat, empty=1, first=last=1, prim_index=base.
//   IDLE, fire, leaf count 1, or LEAF_EXPAND=0: one beat, first=last=1, prim_index=base.
//   IDLE, fire, leaf count N>=2, LEAF_EXPAND=1: beat 0 prim_index=base, first=1;
//    remaining counter=N-1; go EXPAND.
//   EXPAND: on each out handshake load next beat, prim_index+1 (mod 2^20), first=0;
//    last=1 on the beat where remaining reaches 0; that load returns to IDLE.
//    in_ready=0 throughout EXPAND; a leaf occupies exactly N output beats.
//  out_bbox_*, out_is_leaf, out_prim_count replicated on every beat of a node.
//  Output not consumed: out_valid drops after handshake only if no new beat is loaded.
//  rst asserted mid-expansion: outputs clear immediately; remaining beats dropped.
// TESTING
//  T1 interior axis=2,c0=0x0005,c1=0x7FFF,addr=0x100 -> 1 beat next cycle: axis=2,
//     child0=0x105, child1=0x80FF, bbox fields match, first=last=1, is_leaf=0.
//  T2 leaf base=0x00010,count=3, out_ready=1 -> beats prim 0x10,0x11,0x12 on 3
//     consecutive cycles; first on beat0, last on beat2; in_ready=0 until last loaded.
//  T3 leaf count=0 -> single beat empty=1,first=last=1; LEAF_EXPAND=0 with count=5 ->
//     single beat prim_index=base,prim_count=5,first=last=1.
//  T4 out_ready low 5 cycles mid T2 expansion -> outputs stable, no lost/duplicate beats.
//  T5 addr=0xFFFFFFF0,c0=0x20 -> child0=0x00000010; leaf base=0xFFFFF,count=2 ->
//     prim 0xFFFFF then 0x00000.
//  T6 rst pulse during EXPAND -> out_valid=0 same cycle; after release in_ready=1 and
//     next interior node decodes cleanly; 8 back-to-back interiors -> 8 beats/8 cycles.

Source files
------------

// File: rtl/bvh_node_unpacker.sv
// BVH node unpacker: splits a 128-bit packed node word into traversal fields,
// resolves child offsets to absolute addresses and optionally expands leaves.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   node word handshake (in_ready is combinational)
//   in_node_word        {max_z,max_y,max_x,min_z,min_y,min_x,union[31:0]}
//   in_is_leaf          node type sideband
//   in_node_addr        address of the incoming node
//   out_valid/out_ready decoded beat handshake
//   out_*               registered decoded beat fields
module bvh_node_unpacker #(
  parameter int ADDR_W      = 32,
  parameter bit LEAF_EXPAND = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in_node_word,
  input  logic              in_is_leaf,
  input  logic [ADDR_W-1:0] in_node_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_is_leaf,
  output logic [1:0]        out_axis,
  output logic [ADDR_W-1:0] out_child0_addr,
  output logic [ADDR_W-1:0] out_child1_addr,
  output logic [47:0]       out_bbox_min,
  output logic [47:0]       out_bbox_max,
  output logic [19:0]       out_prim_index,
  output logic [11:0]       out_prim_count,
  output logic              out_first,
  output logic              out_last,
  output logic              out_empty
);

  typedef enum logic {IDLE, EXPAND} state_e;

  state_e              state_q;
  logic [11:0]         rem_q;
  logic                valid_q;
  logic                leaf_q;
  logic [1:0]          axis_q;
  logic [ADDR_W-1:0]   c0_q;
  logic [ADDR_W-1:0]   c1_q;
  logic [47:0]         bmin_q;
  logic [47:0]         bmax_q;
  logic [19:0]         pidx_q;
  logic [11:0]         pcnt_q;
  logic                first_q;
  logic                last_q;
  logic                empty_q;

  logic [31:0]         un;
  logic [1:0]          axis_w;
  logic [14:0]         off0_w;
  logic [14:0]         off1_w;
  logic [19:0]         base_w;
  logic [11:0]         cnt_w;
  logic [ADDR_W-1:0]   c0_w;
  logic [ADDR_W-1:0]   c1_w;
  logic                in_fire;
  logic                multi_w;

  assign un     = in_node_word[31:0];
  assign axis_w = un[31:30];
  assign off0_w = un[29:15];
  assign off1_w = un[14:0];
  assign base_w = un[31:12];
  assign cnt_w  = un[11:0];

  assign c0_w = in_node_addr + ADDR_W'(off0_w);
  assign c1_w = in_node_addr + ADDR_W'(off1_w);

  assign in_ready = !rst && (state_q == IDLE)
                    && (!valid_q || out_ready);
  assign in_fire  = in_valid && in_ready;

  // leaf needing more than one beat
  assign multi_w = LEAF_EXPAND && in_is_leaf
                   && (cnt_w > 12'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      valid_q <= 1'b0;
      leaf_q  <= 1'b0;
      axis_q  <= '0;
      c0_q    <= '0;
      c1_q    <= '0;
      bmin_q  <= '0;
      bmax_q  <= '0;
      pidx_q  <= '0;
      pcnt_q  <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      empty_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_fire) begin
            valid_q <= 1'b1;
            leaf_q  <= in_is_leaf;
            bmin_q  <= in_node_word[79:32];
            bmax_q  <= in_node_word[127:80];
            first_q <= 1'b1;
            last_q  <= !multi_w;
            if (in_is_leaf) begin
              axis_q  <= '0;
              c0_q    <= '0;
              c1_q    <= '0;
              pidx_q  <= base_w;
              pcnt_q  <= cnt_w;
              empty_q <= (cnt_w == 12'd0);
            end else begin
              axis_q  <= axis_w;
              c0_q    <= c0_w;
              c1_q    <= c1_w;
              pidx_q  <= '0;
              pcnt_q  <= '0;
              empty_q <= 1'b0;
            end
            if (multi_w) begin
              rem_q   <= cnt_w - 12'd1;
              state_q <= EXPAND;
            end
          end else if (out_ready) begin
            valid_q <= 1'b0;
          end
        end
        EXPAND: begin
          // out_valid is always high here
          if (out_ready) begin
            pidx_q  <= pidx_q + 20'd1;
            first_q <= 1'b0;
            rem_q   <= rem_q - 12'd1;
            if (rem_q == 12'd1) begin
              last_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid       = valid_q;
  assign out_is_leaf     = leaf_q;
  assign out_axis        = axis_q;
  assign out_child0_addr = c0_q;
  assign out_child1_addr = c1_q;
  assign out_bbox_min    = bmin_q;
  assign out_bbox_max    = bmax_q;
  assign out_prim_index  = pidx_q;
  assign out_prim_count  = pcnt_q;
  assign out_first       = first_q;
  assign out_last        = last_q;
  assign out_empty       = empty_q;

endmodule

// File: tb/tb_bvh_node_unpacker.sv
// Bench for bvh_node_unpacker: beat-queue model plus directed node vectors.
// Second instance covers the non-expanding leaf build.
module tb_bvh_node_unpacker;

  typedef struct packed {
    logic        is_leaf;
    logic [1:0]  axis;
    logic [31:0] c0;
    logic [31:0] c1;
    logic [47:0] bmin;
    logic [47:0] bmax;
    logic [19:0] pi;
    logic [11:0] pc;
    logic        first;
    logic        last;
    logic        empty;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_valid_b = 1'b0;
  logic [127:0] in_node_word = '0;
  logic         in_is_leaf = 1'b0;
  logic [31:0]  in_node_addr = '0;
  logic         out_ready = 1'b1;
  logic         out_ready_b = 1'b1;

  logic         in_ready, in_ready_b;
  logic         out_valid, out_valid_b;
  logic         o_leaf, b_leaf;
  logic [1:0]   o_axis, b_axis;
  logic [31:0]  o_c0, o_c1, b_c0, b_c1;
  logic [47:0]  o_bmin, o_bmax, b_bmin, b_bmax;
  logic [19:0]  o_pi, b_pi;
  logic [11:0]  o_pc, b_pc;
  logic         o_first, o_last, o_empty;
  logic         b_first, b_last, b_empty;

  int errors = 0;
  int checks = 0;
  beat_t q[$];

  always #5 clk = ~clk;

  bvh_node_unpacker #(.ADDR_W(32), .LEAF_EXPAND(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_node_word(in_node_word), .in_is_leaf(in_is_leaf),
    .in_node_addr(in_node_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_is_leaf(o_leaf), .out_axis(o_axis),
    .out_child0_addr(o_c0), .out_child1_addr(o_c1),
    .out_bbox_min(o_bmin), .out_bbox_max(o_bmax),
    .out_prim_index(o_pi), .out_prim_count(o_pc),
    .out_first(o_first), .out_last(o_last), .out_empty(o_empty)
  );

  bvh_node_unpacker #(.ADDR_W(32), .LEAF_EXPAND(1'b0)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_node_word(in_node_word), .in_is_leaf(in_is_leaf),
    .in_node_addr(in_node_addr),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_is_leaf(b_leaf), .out_axis(b_axis),
    .out_child0_addr(b_c0), .out_child1_addr(b_c1),
    .out_bbox_min(b_bmin), .out_bbox_max(b_bmax),
    .out_prim_index(b_pi), .out_prim_count(b_pc),
    .out_first(b_first), .out_last(b_last), .out_empty(b_empty)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // expected beat list for one accepted node
  function automatic void push_node(input logic [127:0] w,
                                    input logic leaf,
                                    input logic [31:0] a);
    beat_t b;
    int n;
    logic [31:0] u;
    u = w[31:0];
    b = '0;
    b.is_leaf = leaf;
    b.bmin = w[79:32];
    b.bmax = w[127:80];
    if (!leaf) begin
      b.axis  = u[31:30];
      b.c0    = a + {17'd0, u[29:15]};
      b.c1    = a + {17'd0, u[14:0]};
      b.first = 1'b1;
      b.last  = 1'b1;
      q.push_back(b);
    end else begin
      b.pc    = u[11:0];
      b.empty = (u[11:0] == 12'd0);
      n = (u[11:0] >= 12'd2) ? int'(u[11:0]) : 1;
      for (int i = 0; i < n; i++) begin
        b.pi    = u[31:12] + 20'(i);
        b.first = (i == 0);
        b.last  = (i == n - 1);
        q.push_back(b);
      end
    end
  endfunction

  beat_t act_b;
  always_comb begin
    act_b = '0;
    act_b = {o_leaf, o_axis, o_c0, o_c1, o_bmin, o_bmax,
             o_pi, o_pc, o_first, o_last, o_empty};
  end

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_prim", 64'(o_pi), 64'd0);
    end else begin
      chk("in_ready", 64'(in_ready),
          64'((q.size() == 0) || (q.size() == 1 && out_ready)));
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      if (out_valid && q.size() != 0) begin
        checks++;
        if (act_b !== q[0]) begin
          errors++;
          $display("FAIL beat: got %h expected %h", act_b, q[0]);
        end
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && in_ready)
        push_node(in_node_word, in_is_leaf, in_node_addr);
    end
  end

  task automatic send(input logic [127:0] w, input logic leaf,
                      input logic [31:0] a, output int waits);
    bit ok;
    ok = 0;
    waits = 0;
    in_node_word = w;
    in_is_leaf = leaf;
    in_node_addr = a;
    in_valid = 1'b1;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      else waits++;
    end
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: got no in_ready expected in_ready");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain;
    bit ok;
    ok = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(posedge clk);
      #2;
      if (q.size() == 0 && !out_valid) ok = 1;
    end
    if (!ok) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
  endtask

  function automatic logic [127:0] mk(input logic [31:0] u);
    return {16'h6666, 16'h5555, 16'h4444,
            16'h3333, 16'h2222, 16'h1111, u};
  endfunction

  function automatic logic [31:0] inode(input logic [1:0] ax,
                                        input logic [14:0] o0,
                                        input logic [14:0] o1);
    return {ax, o0, o1};
  endfunction

  int w;
  int wsum;

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // T1 interior decode
    send(mk(inode(2'd2, 15'h0005, 15'h7FFF)), 1'b0, 32'h100, w);
    chk("t1_axis", 64'(o_axis), 64'd2);
    chk("t1_c0", 64'(o_c0), 64'h105);
    chk("t1_c1", 64'(o_c1), 64'h80FF);
    chk("t1_bmin", 64'(o_bmin), 64'h3333_2222_1111);
    chk("t1_bmax", 64'(o_bmax), 64'h6666_5555_4444);
    chk("t1_flags", 64'({o_first, o_last, o_leaf}), 64'b110);
    drain();

    // T2 leaf expansion of 3
    send(mk({20'h00010, 12'd3}), 1'b1, 32'h200, w);
    chk("t2_b0", 64'({o_pi, o_first, o_last}), 64'({20'h10, 2'b10}));
    @(posedge clk); #1;
    chk("t2_b1", 64'({o_pi, o_first, o_last}), 64'({20'h11, 2'b00}));
    chk("t2_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("t2_b2", 64'({o_pi, o_first, o_last}), 64'({20'h12, 2'b01}));
    drain();

    // T3 empty leaf, then non-expanding build
    send(mk({20'h00ABC, 12'd0}), 1'b1, 32'h300, w);
    chk("t3_empty", 64'({o_empty, o_first, o_last, o_pi}),
        64'({3'b111, 20'h00ABC}));
    drain();
    in_node_word = mk({20'h00042, 12'd5});
    in_is_leaf = 1'b1;
    in_valid_b = 1'b1;
    @(posedge clk); #1;
    in_valid_b = 1'b0;
    chk("t3b_beat", 64'({out_valid_b, b_pi, b_pc, b_first, b_last}),
        64'({1'b1, 20'h42, 12'd5, 2'b11}));
    @(posedge clk); #1;
    chk("t3b_single", 64'(out_valid_b), 64'd0);

    // T4 stall mid-expansion
    send(mk({20'h00010, 12'd3}), 1'b1, 32'h400, w);
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("t4_held", 64'({o_pi, o_first}), 64'({20'h11, 1'b0}));
    out_ready = 1'b1;
    drain();

    // T5 address and index wrap
    send(mk(inode(2'd1, 15'h0020, 15'h0000)), 1'b0, 32'hFFFF_FFF0, w);
    chk("t5_c0", 64'(o_c0), 64'h10);
    send(mk({20'hFFFFF, 12'd2}), 1'b1, 32'h0, w);
    chk("t5_p0", 64'(o_pi), 64'hFFFFF);
    @(posedge clk); #1;
    chk("t5_p1", 64'({o_pi, o_last}), 64'({20'h0, 1'b1}));
    drain();

    // T6 reset during expansion, then streaming
    send(mk({20'h00100, 12'd4}), 1'b1, 32'h0, w);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("t6_ready", 64'(in_ready), 64'd1);
    wsum = 0;
    for (int i = 0; i < 8; i++) begin
      send(mk(inode(2'(i), 15'(i), 15'(2 * i))), 1'b0,
           32'h1000 + 32'(i), w);
      wsum += w;
    end
    chk("t6_stream_waits", 64'(wsum), 64'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
